// File: rtl/systolic_skew_feeder.sv
// Input stager for the systolic MAC array: FIFO-buffered column vectors re-timed into a diagonal wavefront.
// Optional statistics counters (stall_cnt, vec_cnt) are built only when SKEW_FEEDER_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no tile open; first pop opens a tile
// STREAM | tile open; pop whenever the FIFO has data, else inject a bubble
// DRAIN  | last vector popped; wait for it to reach lane N-1, then pulse done
module systolic_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                busy,
  output logic                done
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         vec_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(N);
  localparam int EW = N*DATA_W + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state;
  logic [CW-1:0]       drain_cnt;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [EW-1:0]       head;
  logic                head_last;
  logic [N*DATA_W-1:0] head_data;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full && (state != DRAIN);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign push       = in_valid && in_ready;
  // Pop uses the registered count, so a freshly written entry is visible one cycle later.
  assign pop        = (state != DRAIN) && !fifo_empty;
  assign head       = mem[rd_ptr];
  assign head_last  = head[EW-1];
  assign head_data  = head[EW-2:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      // done is registered one cycle early so it coincides with drain_cnt reaching 0.
      done <= (state == DRAIN) && (drain_cnt == CW'(1));
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_last) begin
              state     <= DRAIN;
              drain_cnt <= CW'(N-1);
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (pop && head_last) begin
            state     <= DRAIN;
            drain_cnt <= CW'(N-1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= IDLE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] d_q [i+1];
    logic [i:0]        v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) d_q[k] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= pop ? head_data[i*DATA_W +: DATA_W] : '0;
        v_q[0] <= pop;
        for (int k = 1; k <= i; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign out_data[i*DATA_W +: DATA_W] = d_q[i];
    assign out_valid[i]                 = v_q[i];
  end

`ifdef SKEW_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      vec_cnt   <= '0;
    end else begin
      if (pop && vec_cnt != 32'hFFFF_FFFF) vec_cnt <= vec_cnt + 1'b1;
      if (state == STREAM && fifo_empty && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed scenarios plus a random stream,
// compared every cycle against a queue/timeline model of the feeder.
module tb_systolic_skew_feeder;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;
  logic          in_last;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic          busy;
  logic          done;
`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   vec_cnt;
`endif

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy),
    .done(done)
`ifdef SKEW_FEEDER_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .vec_cnt(vec_cnt)
`endif
  );

  typedef struct {
    logic [63:0] d;
    bit          last;
  } vec_t;

  // Model: vectors waiting, and a timeline of which vector was popped in which cycle.
  vec_t        q[$];
  bit          popped[int];
  logic [63:0] pop_data[int];
  bit          done_at[int];
  int          t = 0;
  int          n_checks = 0;
  int          n_err = 0;
  bit          known = 0;
  bit          stream = 0;
  int          drain_s = 0;
  int          drain_e = -1;
  longint      m_vec = 0;
  longint      m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    popped.delete();
    pop_data.delete();
    done_at.delete();
    stream  = 0;
    drain_s = 0;
    drain_e = -1;
    m_vec   = 0;
    m_stall = 0;
  endtask

  task automatic step(input bit r, input bit v, input logic [63:0] d, input bit l);
    logic [63:0] e_d;
    logic [N-1:0] e_v;
    logic [63:0] pv;
    bit drn;
    bit e_rdy;
    bit e_busy;
    vec_t x;
    rst      = r;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    drn    = (t >= drain_s) && (t <= drain_e);
    e_rdy  = (q.size() < DEPTH) && !drn;
    e_busy = (q.size() > 0) || stream || drn;
    if (known) begin
      e_d = '0;
      e_v = '0;
      for (int i = 0; i < N; i++) begin
        if (popped.exists(t-1-i)) begin
          pv = pop_data[t-1-i];
          e_v[i] = 1'b1;
          e_d[i*DW +: DW] = pv[i*DW +: DW];
        end
      end
      chk("out_data",  out_data, e_d);
      chk("out_valid", 64'(out_valid), 64'(e_v));
      chk("done",      64'(done), 64'(done_at.exists(t)));
      chk("busy",      64'(busy), 64'(e_busy));
      chk("in_ready",  64'(in_ready), 64'(e_rdy));
`ifdef SKEW_FEEDER_STATS_EN
      chk("vec_cnt",   64'(vec_cnt), 64'(m_vec));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
    if (r) begin
      model_clear();
      known = 1;
    end else begin
      if (!drn && q.size() > 0) begin
        x = q.pop_front();
        popped[t]   = 1;
        pop_data[t] = x.d;
        m_vec++;
        if (x.last) begin
          stream  = 0;
          drain_s = t + 1;
          drain_e = t + N;
          done_at[t+N] = 1;
        end else begin
          stream = 1;
        end
      end else if (stream) begin
        m_stall++;
      end
      if (v && e_rdy) begin
        x.d = d;
        x.last = l;
        q.push_back(x);
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 64'h0, 0);
  endtask

  initial begin
    logic [63:0] col;
    rst = 1; in_valid = 0; in_data = '0; in_last = 0;
    @(posedge clk);
    #1;
    // Reset held two cycles.
    step(1, 0, 64'h0, 0);
    step(1, 0, 64'h0, 0);
    idle(2);

    // Single-vector tile {1.0, 2.0, 3.0, 4.0}.
    step(0, 1, 64'h0400_0300_0200_0100, 1);
    idle(7);

    // Three back-to-back columns, col k lane j = k*0x100 + j.
    for (int k = 0; k < 3; k++) begin
      col = '0;
      for (int j = 0; j < N; j++) col[j*DW +: DW] = 16'(k*256 + j);
      step(0, 1, col, k == 2);
    end
    idle(9);

    // Bubble: A, idle, B(last), counters from a fresh reset.
    step(1, 0, 64'h0, 0);
    step(0, 1, 64'h8001_7fff_00ff_ff00, 0);
    step(0, 0, 64'h0, 0);
    step(0, 1, 64'h1234_5678_9abc_def0, 1);
    idle(7);

    // Backpressure: in_valid held through DRAIN and beyond.
    step(0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1);
    for (int i = 0; i < 14; i++) step(0, 1, {$urandom, $urandom}, i == 13);
    idle(10);

    // Reset mid-tile at P+2.
    step(0, 1, 64'h0400_0300_0200_0100, 1);
    idle(2);
    step(1, 0, 64'h0, 0);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(0, ($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 5) == 0);
    step(0, 1, {$urandom, $urandom}, 1);
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
